// File: rtl/mtr_pwm_drv.sv
// Dual-channel H-bridge PWM driver.
// Takes the signed left/right wheel speed commands and drives two complementary,
// dead-time protected 11-bit PWM channels. Both channels share one period counter.
// Duty is latched only at the end of a period, so a new command never changes a
// period that is already running.
//
// Dead-time FSM, one instance per channel:
//   state   | meaning
//   LOW_ON  | low-side gate on  (PWM1=0, PWM2=1)
//   DEAD    | both gates off, dcnt counting the non-overlap window
//   HIGH_ON | high-side gate on (PWM1=1, PWM2=0)
//
// The FSM watches the next value of raw_q. A raw edge therefore drops both gates
// in the same cycle that raw_q changes. The opposite gate turns on NONOVERLAP
// cycles later, unless raw toggles again first; in that case the window restarts.
module mtr_pwm_drv #(
  parameter int unsigned NONOVERLAP = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        lftPWM1,
  output logic        lftPWM2,
  output logic        rghtPWM1,
  output logic        rghtPWM2,
  output logic        prd_strt
);

  typedef enum logic [1:0] {
    LOW_ON  = 2'd0,
    DEAD    = 2'd1,
    HIGH_ON = 2'd2
  } dt_state_e;

  localparam logic [5:0] DCNT_LAST = 6'(NONOVERLAP - 1);

  // -1024 has no positive mirror; clamp it to -1023 so the duty stays in 1..2047.
  function automatic logic [10:0] spd2duty(input logic [10:0] spd);
    logic [10:0] clamped;
    clamped = (spd == 11'h400) ? 11'h401 : spd;
    return 11'h400 + clamped;
  endfunction

  logic [10:0]      cnt_q, cnt_d;
  logic             prd_q, prd_d;
  logic [1:0][10:0] spd_w;
  logic [1:0]       pwm1_w, pwm2_w;

  assign spd_w = {rght_spd, lft_spd};

  // Shared period counter; parked at 0 while disabled so enabling starts a fresh period.
  always_comb begin
    cnt_d = en ? (cnt_q + 11'd1) : 11'd0;
    prd_d = en && (cnt_q == 11'd0);
  end

  // Period counter and period-start pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 11'd0;
      prd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      prd_q <= prd_d;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [10:0] duty_q, duty_d;
    logic        raw_q, raw_d;
    dt_state_e   state_q, state_d;
    logic [5:0]  dcnt_q, dcnt_d;
    logic        pwm1_q, pwm1_d;
    logic        pwm2_q, pwm2_d;

    // Duty latch (end of period or while disabled) and raw duty comparator.
    always_comb begin
      duty_d = duty_q;
      if (!en || (cnt_q == 11'h7FF)) begin
        duty_d = spd2duty(spd_w[ch]);
      end
      raw_d = en && (cnt_q < duty_q);
    end

    // State register: duty, raw compare, dead-time FSM and gate outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        duty_q  <= 11'h400;
        raw_q   <= 1'b0;
        state_q <= DEAD;
        dcnt_q  <= 6'd0;
        pwm1_q  <= 1'b0;
        pwm2_q  <= 1'b0;
      end else begin
        duty_q  <= duty_d;
        raw_q   <= raw_d;
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        pwm1_q  <= pwm1_d;
        pwm2_q  <= pwm2_d;
      end
    end

    // Next-state logic: a raw edge or disable always wins over the dead-time terminal count.
    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      if (!en || (raw_d != raw_q)) begin
        state_d = DEAD;
        dcnt_d  = 6'd0;
      end else if (state_q == DEAD) begin
        if (dcnt_q == DCNT_LAST) begin
          state_d = raw_q ? HIGH_ON : LOW_ON;
          dcnt_d  = 6'd0;
        end else begin
          dcnt_d = dcnt_q + 6'd1;
        end
      end
    end

    // Output decode from the next state; the gates are registered to stay glitch-free.
    always_comb begin
      pwm1_d = (state_d == HIGH_ON);
      pwm2_d = (state_d == LOW_ON);
    end

    assign pwm1_w[ch] = pwm1_q;
    assign pwm2_w[ch] = pwm2_q;
  end

  assign lftPWM1  = pwm1_w[0];
  assign lftPWM2  = pwm2_w[0];
  assign rghtPWM1 = pwm1_w[1];
  assign rghtPWM2 = pwm2_w[1];
  assign prd_strt = prd_q;

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Directed + random bench for mtr_pwm_drv.
// Per-period gate-high counts are predicted from the commanded speed and queued
// when the speed is driven. Each measured period pops one prediction and compares.
// Overlap and dead-time invariants are checked every cycle.
`timescale 1ns/1ps
module tb_mtr_pwm_drv;
  localparam int N   = 32;
  localparam int PRD = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt;

  mtr_pwm_drv #(.NONOVERLAP(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .lftPWM1  (lftPWM1),
    .lftPWM2  (lftPWM2),
    .rghtPWM1 (rghtPWM1),
    .rghtPWM2 (rghtPWM2),
    .prd_strt (prd_strt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int l1;
    int l2;
    int r1;
    int r2;
  } exp_t;

  exp_t sb[$];
  int   errs   = 0;
  int   checks = 0;
  int   cur_l  = 0;
  int   cur_r  = 0;
  int   lowrun[2];
  bit   pv1[2];
  bit   pv2[2];

  function automatic int duty_of(input int s);
    int v;
    v = s;
    if (v < -1023) v = -1023;
    return 1024 + v;
  endfunction

  // Gate on-time within a raw pulse of length len: the first N cycles are dead time.
  function automatic int hi_time(input int len);
    return (len > N) ? (len - N) : 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      if (errs <= 20) $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic [1:0] p1;
    logic [1:0] p2;
    @(negedge clk);
    p1 = {rghtPWM1, lftPWM1};
    p2 = {rghtPWM2, lftPWM2};
    for (int ch = 0; ch < 2; ch++) begin
      if (!rst) begin
        chk((ch == 0) ? "overlap_lft" : "overlap_rght", int'(p1[ch] & p2[ch]), 0);
        if ((p1[ch] && !pv1[ch]) || (p2[ch] && !pv2[ch]))
          chk($sformatf("deadtime_ch%0d_run%0d", ch, lowrun[ch]), int'(lowrun[ch] >= N), 1);
      end
      lowrun[ch] = (!p1[ch] && !p2[ch]) ? lowrun[ch] + 1 : 0;
      pv1[ch]    = p1[ch];
      pv2[ch]    = p2[ch];
    end
  endtask

  task automatic push_exp(input int l, input int r);
    exp_t e;
    e.l1 = hi_time(duty_of(l));
    e.l2 = hi_time(PRD - duty_of(l));
    e.r1 = hi_time(duty_of(r));
    e.r2 = hi_time(PRD - duty_of(r));
    sb.push_back(e);
  endtask

  task automatic drive_spd(input int l, input int r);
    lft_spd  = 11'(l);
    rght_spd = 11'(r);
    cur_l    = l;
    cur_r    = r;
    push_exp(l, r);
  endtask

  task automatic outs_zero(input string tag);
    chk(tag, int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, prd_strt}), 0);
  endtask

  // Measure one full period starting at the next prd_strt; optionally drive new speeds mid-period.
  task automatic measure(input string tag, input int chg_at, input int nl, input int nr);
    exp_t e;
    int   c1l = 0, c2l = 0, c1r = 0, c2r = 0, np = 0, guard = 0;
    while (prd_strt !== 1'b1 && guard < 3 * PRD) begin
      tick();
      guard++;
    end
    chk({tag, "_prd_found"}, int'(prd_strt), 1);
    if (prd_strt !== 1'b1) return;
    for (int i = 0; i < PRD; i++) begin
      if (i == chg_at) drive_spd(nl, nr);
      c1l += int'(lftPWM1);
      c2l += int'(lftPWM2);
      c1r += int'(rghtPWM1);
      c2r += int'(rghtPWM2);
      np  += int'(prd_strt);
      tick();
    end
    chk({tag, "_prd_count"}, np, 1);
    chk({tag, "_sb_nonempty"}, int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_lftPWM1_hi"}, c1l, e.l1);
      chk({tag, "_lftPWM2_hi"}, c2l, e.l2);
      chk({tag, "_rghtPWM1_hi"}, c1r, e.r1);
      chk({tag, "_rghtPWM2_hi"}, c2r, e.r2);
    end
  endtask

  function automatic int rnd_spd();
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lowrun = '{0, 0};
    pv1    = '{0, 0};
    pv2    = '{0, 0};
    rst      = 1'b1;
    en       = 1'b1;
    lft_spd  = 11'd0;
    rght_spd = 11'd0;

    for (int i = 0; i < 3; i++) begin
      tick();
      outs_zero($sformatf("reset_outs_%0d", i));
    end
    rst = 1'b0;
    drive_spd(0, 0);

    // Speed 0: 50% raw duty on both channels.
    measure("t1_a", -1, 0, 0);
    push_exp(cur_l, cur_r);
    measure("t1_b", 500, 1023, 0);

    // Full forward, then -1024 which must behave as -1023.
    push_exp(cur_l, cur_r);
    measure("t2_a", -1, 0, 0);
    measure("t2_b", 200, -1024, 0);
    measure("t3_m1024", 200, -1023, 0);

    // Right speed changed at cnt 300 must not touch the running period.
    measure("t3_m1023", 300, -1023, 512);
    measure("t4_r512", -1, 0, 0);

    // Disable mid-period, change speed while off, re-enable.
    for (int i = 0; i < 900; i++) tick();
    en = 1'b0;
    tick();
    outs_zero("t5_off_next_cycle");
    drive_spd(-300, 700);
    for (int i = 0; i < 5; i++) begin
      tick();
      outs_zero($sformatf("t5_off_hold_%0d", i));
    end
    en = 1'b1;
    tick();
    chk("t5_prd_on_reenable", int'(prd_strt), 1);
    measure("t5_reen", 1000, rnd_spd(), rnd_spd());

    // Random speeds, changed at random points within each period.
    for (int k = 0; k < 12; k++) begin
      measure($sformatf("rnd%0d", k),
              (k < 11) ? int'($urandom_range(10, 2000)) : -1,
              rnd_spd(), rnd_spd());
    end

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
